// File: rtl/rtype_encoder_if.sv
// Request/response bundle for rtype_encoder: encode requests in, instruction words out.
// master = request source and word consumer, slave = the encoder.
interface rtype_encoder_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [9:0]               op_en;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [4:0]               rd;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              instruction;
  logic                     illegal;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, op_en, rs1, rs2, rd, out_ready,
    input  in_ready, out_valid, instruction, illegal, count
  );

  modport slave (
    input  in_valid, op_en, rs1, rs2, rd, out_ready,
    output in_ready, out_valid, instruction, illegal, count
  );
endinterface

// File: rtl/rtype_encoder.sv
// Encodes one-hot RV32I R-type op selects into 32-bit words and queues them in a
// DEPTH-entry FIFO; non-one-hot requests are consumed but dropped and flagged.
module rtype_encoder #(
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset,
  rtype_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          illegal_q, illegal_d;

  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   word;

  // The case only matches exactly-one-bit patterns, so it doubles as the one-hot check.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    legal  = 1'b1;
    case (bus.op_en)
      10'b00_0000_0001: funct3 = 3'b000;                              // add
      10'b00_0000_0010: begin funct3 = 3'b000; funct7 = 7'b0100000; end // sub
      10'b00_0000_0100: funct3 = 3'b111;                              // and
      10'b00_0000_1000: funct3 = 3'b110;                              // or
      10'b00_0001_0000: funct3 = 3'b001;                              // sll
      10'b00_0010_0000: funct3 = 3'b010;                              // slt
      10'b00_0100_0000: funct3 = 3'b011;                              // sltu
      10'b00_1000_0000: funct3 = 3'b100;                              // xor
      10'b01_0000_0000: funct3 = 3'b101;                              // srl
      10'b10_0000_0000: begin funct3 = 3'b101; funct7 = 7'b0100000; end // sra
      default:          legal  = 1'b0;
    endcase
    word = {funct7, bus.rs2, bus.rs1, funct3, bus.rd, OPCODE_OP};
  end

  // Status comes from registered occupancy only; no in_valid/out_ready feedthrough.
  assign bus.in_ready    = (count_q != CW'(DEPTH));
  assign bus.out_valid   = (count_q != '0);
  assign bus.instruction = bus.out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign bus.illegal     = illegal_q;
  assign bus.count       = count_q;

  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    push      = accept && legal;
    pop       = bus.out_valid && bus.out_ready;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    illegal_d = accept && !legal;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: the storage array is not reset; count_q alone decides which entries are meaningful.
    if (push) mem_q[wr_ptr_q] <= word;
  end
endmodule

// File: tb/tb_rtype_encoder.sv
// Scoreboard bench for rtype_encoder: the driver queues expected words on accept,
// a negedge monitor pops and compares them and checks status against queue occupancy.
module tb_rtype_encoder;
  localparam int DEPTH = 4;

  logic clock;
  logic reset;
  rtype_encoder_if #(.DEPTH(DEPTH)) bus ();

  rtype_encoder #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] pending_word;
  bit          ill_exp  = 1'b0;
  bit          mon_en   = 1'b0;
  int          rdy_mode = 0;   // 0: hold off, 1: always ready, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the op tables, not from the RTL's case structure.
  function automatic logic [31:0] model_encode(input logic [9:0] op, input logic [4:0] r1,
                                               input logic [4:0] r2, input logic [4:0] d);
    int f3_tbl [10] = '{0, 0, 7, 6, 1, 2, 3, 4, 5, 5};
    int idx = 0;
    int f7;
    for (int i = 0; i < 10; i++) if (op[i]) idx = i;
    f7 = (idx == 1 || idx == 9) ? 32 : 0;
    return 32'(f7 * (1 << 25) + int'(r2) * (1 << 20) + int'(r1) * (1 << 15)
               + f3_tbl[idx] * (1 << 12) + int'(d) * (1 << 7) + 'h33);
  endfunction

  function automatic bit is_onehot(input logic [9:0] op);
    return $countones(op) == 1;
  endfunction

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: status must follow scoreboard occupancy; head word must match the queue front.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      check("count", 32'(bus.count), 32'(exp_q.size()));
      check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() != DEPTH));
      check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check("illegal", 32'(bus.illegal), 32'(ill_exp));
      if (exp_q.size() == 0) begin
        check("instr_idle", bus.instruction, 32'h0);
      end else if (bus.out_ready) begin
        check("instr", bus.instruction, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock cycle of the driver; pushes the expected word when the request is taken.
  task automatic tick(output bit acc);
    bit legal;
    @(negedge clock);
    acc   = bus.in_valid && bus.in_ready && !reset;
    legal = is_onehot(bus.op_en);
    @(posedge clock);
    if (reset) begin
      exp_q.delete();
      ill_exp = 1'b0;
    end else begin
      if (acc && legal) exp_q.push_back(pending_word);
      ill_exp = acc && !legal;
    end
    #1;
  endtask

  task automatic send(input logic [9:0] op, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] d, input bit use_fixed, input logic [31:0] fixed,
                      input int release_after, output int cycles);
    bit acc;
    cycles       = 0;
    bus.in_valid = 1'b1;
    bus.op_en    = op;
    bus.rs1      = r1;
    bus.rs2      = r2;
    bus.rd       = d;
    pending_word = use_fixed ? fixed : model_encode(op, r1, r2, d);
    do begin
      tick(acc);
      cycles++;
      if (!acc && cycles == release_after) rdy_mode = 1;
    end while (!acc && cycles < 64);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [9:0] op);
    int cyc;
    send(op, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 32'h0, -1, cyc);
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.in_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  task automatic drain();
    int guard = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && guard < 64) begin
      idle(1);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int total;
    logic [9:0] op;
    bit acc;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.op_en    = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;
    bus.rd       = '0;
    rdy_mode     = 1;
    repeat (2) tick(acc);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(1);

    // Single add x3,x1,x2 held at the head, then popped.
    rdy_mode = 0;
    send(10'b00_0000_0001, 5'd1, 5'd2, 5'd3, 1'b1, 32'h002081B3, -1, cyc);
    idle(2);
    drain();

    // Every op, with the three known-good encodings pinned.
    for (int i = 0; i < 10; i++) begin
      op = 10'(1 << i);
      case (i)
        1:       send(op, 5'd6, 5'd7, 5'd5, 1'b1, 32'h407302B3, -1, cyc);
        2:       send(op, 5'd0, 5'd0, 5'd0, 1'b1, 32'h00007033, -1, cyc);
        9:       send(op, 5'd31, 5'd31, 5'd31, 1'b1, 32'h41FFDFB3, -1, cyc);
        default: send_rand(op);
      endcase
    end
    drain();

    // Fill to DEPTH with the consumer stalled; the fifth request must wait.
    rdy_mode = 0;
    for (int i = 0; i < DEPTH; i++) send_rand(10'(1 << (i % 10)));
    send(10'b10_0000_0000, 5'd9, 5'd10, 5'd11, 1'b0, 32'h0, 3, cyc);
    check("fifth_held_off", 32'(cyc > 3), 32'd1);
    drain();

    // Back-to-back stream: one accept per cycle with the consumer always ready.
    rdy_mode = 1;
    idle(1);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      send(10'(1 << $urandom_range(0, 9)), 5'($urandom), 5'($urandom), 5'($urandom),
           1'b0, 32'h0, -1, cyc);
      total += cyc;
    end
    check("stream_cycles", 32'(total), 32'd10);
    drain();

    // Non-one-hot requests are consumed but never stored.
    send(10'b00_0000_0011, 5'd1, 5'd2, 5'd3, 1'b0, 32'h0, -1, cyc);
    send(10'b00_0000_0000, 5'd4, 5'd5, 5'd6, 1'b0, 32'h0, -1, cyc);
    idle(1);
    send(10'b00_0000_0001, 5'd1, 5'd2, 5'd3, 1'b1, 32'h002081B3, -1, cyc);
    drain();

    // Reset with three words buffered and a request presented in the reset cycle.
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send_rand(10'(1 << (i + 4)));
    bus.in_valid = 1'b1;
    bus.op_en    = 10'b00_0000_0001;
    pending_word = model_encode(bus.op_en, bus.rs1, bus.rs2, bus.rd);
    reset        = 1'b1;
    tick(acc);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    idle(2);

    // Randomised traffic, including occasional malformed op selects.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) op = 10'($urandom);
      else                           op = 10'(1 << $urandom_range(0, 9));
      send_rand(op);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
